// File: rtl/seed_word_loader.sv
// -----------------------------------------------------------------------------
// seed_word_loader
//
// Adapter between a 32-bit valid/ready word stream and the SEED128 core.
// It takes one operation at a time:
//   1. collects eight input words (key0..key3, data0..data3, MS word first)
//      and the mode bit, which is sampled with the key0 beat;
//   2. drives the core's two-cycle load protocol on o_Data: the block with
//      bit 128 set, then {mode, key};
//   3. waits for the core's done pulse and captures the 128-bit result,
//      giving up after TIMEOUT cycles and raising a sticky timeout flag;
//   4. returns the result as four 32-bit words, MS word first.
//
// Ports
//   i_Clk       clock, all logic on the rising edge
//   i_Rst       synchronous active-high reset (reset the core with it)
//   i_Word      input word stream data
//   i_fValid    input word valid
//   i_fDec      mode bit, 1 = decrypt, sampled with the key0 beat only
//   o_fReady    input ready, high only while collecting
//   o_Data      to core i_Data; bit 128 is the core's first/mode flag
//   i_Text      from core o_Text, only meaningful while i_fDone is high
//   i_fDone     from core o_fDone, one-cycle done pulse
//   o_Word      result word, MS word first
//   o_fValid    result word valid
//   i_fReady    result word ready
//   o_fBusy     high whenever not collecting input
//   o_fTimeout  sticky timeout flag, cleared only by reset
//
// Parameter
//   TIMEOUT     cycles allowed in WAIT before giving up (legal 120..255)
// -----------------------------------------------------------------------------
module seed_word_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [31:0]  i_Word,
  input  logic         i_fValid,
  input  logic         i_fDec,
  output logic         o_fReady,
  output logic [128:0] o_Data,
  input  logic [127:0] i_Text,
  input  logic         i_fDone,
  output logic [31:0]  o_Word,
  output logic         o_fValid,
  input  logic         i_fReady,
  output logic         o_fBusy,
  output logic         o_fTimeout
);

  localparam logic [2:0] ST_COLLECT  = 3'd0;
  localparam logic [2:0] ST_LOAD_BLK = 3'd1;
  localparam logic [2:0] ST_LOAD_KEY = 3'd2;
  localparam logic [2:0] ST_WAIT     = 3'd3;
  localparam logic [2:0] ST_OUT      = 3'd4;

  // The counter holds 0 during the first WAIT cycle, so the timeout fires on
  // the edge that closes WAIT cycle number TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [2:0]   state_q,   state_d;
  logic [2:0]   beat_q,    beat_d;
  logic [1:0]   out_idx_q, out_idx_d;
  logic [7:0]   tmo_cnt_q, tmo_cnt_d;
  logic [127:0] key_q,     key_d;
  logic [127:0] block_q,   block_d;
  logic [127:0] result_q,  result_d;
  logic         mode_q,    mode_d;
  logic         timeout_q, timeout_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = i_fValid & (state_q == ST_COLLECT);
  assign out_fire = i_fReady & (state_q == ST_OUT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every next-state value defaults to its register first, so paths
    // that do not assign it simply hold and no latch is inferred.
    state_d   = state_q;
    beat_d    = beat_q;
    out_idx_d = out_idx_q;
    tmo_cnt_d = tmo_cnt_q;
    key_d     = key_q;
    block_d   = block_q;
    result_d  = result_q;
    mode_d    = mode_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_COLLECT: begin
        if (in_fire) begin
          // Words arrive MS first, so shifting in from the bottom leaves the
          // first word of each group in bits [127:96].
          if (!beat_q[2]) begin
            key_d = {key_q[95:0], i_Word};
          end else begin
            block_d = {block_q[95:0], i_Word};
          end
          if (beat_q == 3'd0) begin
            mode_d = i_fDec;
          end
          // 3-bit count wraps 7 -> 0, ready for the next frame.
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            state_d = ST_LOAD_BLK;
          end
        end
      end

      ST_LOAD_BLK: begin
        state_d = ST_LOAD_KEY;
      end

      ST_LOAD_KEY: begin
        tmo_cnt_d = 8'd0;
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        // Done has priority over the timeout when both land on the same edge.
        if (i_fDone) begin
          result_d  = i_Text;
          out_idx_d = 2'd0;
          state_d   = ST_OUT;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_COLLECT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      ST_OUT: begin
        if (out_fire) begin
          out_idx_d = out_idx_q + 2'd1;
          if (out_idx_q == 2'd3) begin
            state_d = ST_COLLECT;
          end
        end
      end

      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      // NOTE: the wide key/block/result registers are reset as well, so no
      // captured data survives a reset that lands mid-operation.
      state_q   <= ST_COLLECT;
      beat_q    <= 3'd0;
      out_idx_q <= 2'd0;
      tmo_cnt_q <= 8'd0;
      key_q     <= '0;
      block_q   <= '0;
      result_q  <= '0;
      mode_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      beat_q    <= beat_d;
      out_idx_q <= out_idx_d;
      tmo_cnt_q <= tmo_cnt_d;
      key_q     <= key_d;
      block_q   <= block_d;
      result_q  <= result_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from the registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    o_Data = '0;
    case (state_q)
      // Core is in IDLE: bit 128 set tells it this is the block.
      ST_LOAD_BLK: o_Data = {1'b1, block_q};
      // Core is in GETKEY: bit 128 now carries the mode.
      ST_LOAD_KEY: o_Data = {mode_q, key_q};
      // Everywhere else bit 128 must stay low so the core does not restart.
      default:     o_Data = '0;
    endcase
  end

  always_comb begin
    o_Word = result_q[127:96];
    case (out_idx_q)
      2'd0:    o_Word = result_q[127:96];
      2'd1:    o_Word = result_q[95:64];
      2'd2:    o_Word = result_q[63:32];
      default: o_Word = result_q[31:0];
    endcase
  end

  assign o_fReady   = (state_q == ST_COLLECT);
  assign o_fBusy    = (state_q != ST_COLLECT);
  assign o_fValid   = (state_q == ST_OUT);
  assign o_fTimeout = timeout_q;

endmodule

// File: tb/tb_seed_word_loader.sv
// -----------------------------------------------------------------------------
// tb_seed_word_loader
//
// Self-checking bench for seed_word_loader. A behavioural stand-in for the
// SEED128 core latches the block and key/mode from o_Data using the core's
// load protocol, then pulses done after a programmable number of WAIT cycles
// with a result derived from what it latched (known SEED vectors for the
// reference key/block pairs, a simple mixing function otherwise). Expected
// output words are computed from the frames the bench sends.
// -----------------------------------------------------------------------------
module tb_seed_word_loader;

  localparam int unsigned TB_TIMEOUT = 200;
  localparam logic [127:0] PT = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] CT = 128'h5EBAC6E0_054E1668_19AFF1CC_6D346CDB;

  logic         i_Clk = 1'b0;
  logic         i_Rst;
  logic [31:0]  i_Word;
  logic         i_fValid;
  logic         i_fDec;
  logic         o_fReady;
  logic [128:0] o_Data;
  logic [127:0] i_Text;
  logic         i_fDone;
  logic [31:0]  o_Word;
  logic         o_fValid;
  logic         i_fReady;
  logic         o_fBusy;
  logic         o_fTimeout;

  int checks = 0;
  int fails  = 0;

  seed_word_loader #(.TIMEOUT(TB_TIMEOUT)) dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Word     (i_Word),
    .i_fValid   (i_fValid),
    .i_fDec     (i_fDec),
    .o_fReady   (o_fReady),
    .o_Data     (o_Data),
    .i_Text     (i_Text),
    .i_fDone    (i_fDone),
    .o_Word     (o_Word),
    .o_fValid   (o_fValid),
    .i_fReady   (i_fReady),
    .o_fBusy    (o_fBusy),
    .o_fTimeout (o_fTimeout)
  );

  always #5 i_Clk = ~i_Clk;

  // Edge counter: value before increment identifies the edge.
  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  // Result the stand-in core produces for a given load.
  function automatic logic [127:0] core_func(input logic [127:0] k,
                                             input logic [127:0] b,
                                             input logic m);
    if (k == '0 && !m && b == PT) return CT;
    if (k == '0 &&  m && b == CT) return PT;
    return b ^ {k[63:0], k[127:64]} ^ {4{m ? 32'hA5A5_5A5A : 32'h3C3C_C3C3}};
  endfunction

  // ---------------------------------------------------------------------------
  // Stand-in core: IDLE -> (bit128) GETKEY -> BUSY -> done pulse -> IDLE
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {S_IDLE, S_GETKEY, S_BUSY} stub_state_e;
  stub_state_e  s_st;
  logic [127:0] s_blk, s_key;
  logic         s_mode;
  int           s_cnt;
  int           stub_lat = 82;   // done is high during WAIT cycle stub_lat
  int           entry_edge = 0;  // edge on which the DUT entered WAIT
  logic         done_q;
  logic [127:0] text_q;

  always @(posedge i_Clk) begin
    if (i_Rst) begin
      s_st   <= S_IDLE;
      done_q <= 1'b0;
      text_q <= '0;
      s_cnt  <= 0;
    end else begin
      done_q <= 1'b0;
      text_q <= '0;
      case (s_st)
        S_IDLE: if (o_Data[128]) begin
          s_blk <= o_Data[127:0];
          s_st  <= S_GETKEY;
        end
        S_GETKEY: begin
          s_key      <= o_Data[127:0];
          s_mode     <= o_Data[128];
          s_cnt      <= 0;
          entry_edge <= cyc;
          s_st       <= S_BUSY;
        end
        default: begin
          s_cnt <= s_cnt + 1;
          if (s_cnt == stub_lat - 2) begin
            done_q <= 1'b1;
            text_q <= core_func(s_key, s_blk, s_mode);
            s_st   <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign i_fDone = done_q;
  assign i_Text  = text_q;

  // Monitor: bit-128 high cycles and o_Data outside the load states.
  int hi128     = 0;
  int odata_bad = 0;
  int done_seen = 0;
  always @(negedge i_Clk) begin
    if (o_Data[128]) hi128 <= hi128 + 1;
    if ((o_fReady || o_fValid) && o_Data !== '0) odata_bad <= odata_bad + 1;
    if (i_fDone) done_seen <= done_seen + 1;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [128:0] got,
                       input logic [128:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic dec);
    int g = 0;
    i_Word   = w;
    i_fDec   = dec;
    i_fValid = 1'b1;
    while (!o_fReady && g < 400) begin
      @(negedge i_Clk);
      g++;
    end
    check("in_ready", 129'(o_fReady), 129'(1));
    @(negedge i_Clk);
    i_fValid = 1'b0;
    i_fDec   = 1'($urandom);
  endtask

  task automatic send_frame(input logic [127:0] k, input logic [127:0] b,
                            input logic dec, input bit gaps);
    logic [255:0] frame;
    frame = {k, b};
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge i_Clk);
      send_word(frame[255 - 32*i -: 32], (i == 0) ? dec : 1'($urandom));
    end
  endtask

  task automatic recv_result(input logic [127:0] exp, input int stall,
                             input string tag);
    logic [31:0] held;
    bit          stable;
    for (int i = 0; i < 4; i++) begin
      int g = 0;
      while (!o_fValid && g < 600) begin
        @(negedge i_Clk);
        g++;
      end
      check({tag, "_valid"}, 129'(o_fValid), 129'(1));
      if (stall > 0) begin
        held   = o_Word;
        stable = 1'b1;
        i_fReady = 1'b0;
        repeat (stall) begin
          @(negedge i_Clk);
          if (o_Word !== held || o_fValid !== 1'b1) stable = 1'b0;
        end
        check({tag, "_stable"}, 129'(stable), 129'(1));
      end
      check({tag, "_word"}, 129'(o_Word), 129'(exp[127 - 32*i -: 32]));
      i_fReady = 1'b1;
      @(negedge i_Clk);
      i_fReady = 1'b0;
    end
    // Exactly four words: the stream ends and input reopens at once.
    check({tag, "_end_valid"}, 129'(o_fValid), 129'(0));
    check({tag, "_end_ready"}, 129'(o_fReady), 129'(1));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Hard stop if the sequence ever wedges.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [127:0] k, b;
    logic         m;
    int           h0, g;

    i_Rst = 1'b1; i_Word = '0; i_fValid = 1'b0; i_fDec = 1'b0; i_fReady = 1'b0;
    repeat (2) @(negedge i_Clk);
    check("rst_odata",   o_Data, '0);
    check("rst_timeout", 129'(o_fTimeout), 129'(0));
    i_Rst = 1'b0;
    @(negedge i_Clk);
    check("idle_ready", 129'(o_fReady), 129'(1));
    check("idle_busy",  129'(o_fBusy),  129'(0));
    check("idle_valid", 129'(o_fValid), 129'(0));
    check("idle_odata", o_Data, '0);

    // Encrypt reference vector, bit 128 high for one cycle only.
    stub_lat = 82;
    h0 = hi128;
    send_frame('0, PT, 1'b0, 1'b0);
    check("load_blk_odata", o_Data, {1'b1, PT});
    check("load_busy",      129'(o_fBusy),  129'(1));
    check("load_ready",     129'(o_fReady), 129'(0));
    recv_result(CT, 0, "enc");
    check("enc_bit128_cycles", 129'(hi128 - h0), 129'(1));

    // Decrypt round trip: block and mode cycles both carry bit 128.
    stub_lat = 114;
    h0 = hi128;
    send_frame('0, CT, 1'b1, 1'b0);
    recv_result(PT, 0, "dec");
    check("dec_bit128_cycles", 129'(hi128 - h0), 129'(2));

    // Backpressure on both sides.
    k = rnd128(); b = rnd128(); m = 1'($urandom);
    stub_lat = m ? 114 : 82;
    send_frame(k, b, m, 1'b1);
    recv_result(core_func(k, b, m), 10, "bp");

    // Reset in the middle of a frame, then a clean frame.
    for (int i = 0; i < 5; i++) send_word($urandom, 1'b1);
    i_Rst = 1'b1;
    check("midrst_odata_pre", o_Data, '0);
    @(negedge i_Clk);
    check("midrst_odata",   o_Data, '0);
    check("midrst_timeout", 129'(o_fTimeout), 129'(0));
    i_Rst = 1'b0;
    k = rnd128(); b = rnd128();
    stub_lat = 82;
    send_frame(k, b, 1'b0, 1'b0);
    recv_result(core_func(k, b, 1'b0), 0, "midrst");

    // A few random operations.
    for (int n = 0; n < 3; n++) begin
      k = rnd128(); b = rnd128(); m = 1'($urandom);
      stub_lat = m ? 114 : 82;
      send_frame(k, b, m, 1'($urandom));
      recv_result(core_func(k, b, m), $urandom_range(0, 3), "rnd");
    end

    // Timeout: done arrives five cycles after the flag and must be ignored.
    stub_lat = TB_TIMEOUT + 6;
    h0 = done_seen;
    send_frame(rnd128(), rnd128(), 1'b0, 1'b0);
    g = 0;
    while (!o_fTimeout && g < 600) begin
      @(negedge i_Clk);
      g++;
    end
    check("tmo_flag",    129'(o_fTimeout), 129'(1));
    check("tmo_latency", 129'(cyc - 1 - entry_edge), 129'(TB_TIMEOUT));
    check("tmo_busy",    129'(o_fBusy),  129'(0));
    check("tmo_ready",   129'(o_fReady), 129'(1));
    g = 0;
    repeat (12) begin
      @(negedge i_Clk);
      if (o_fValid) g++;
    end
    check("stray_done_seen",  129'(done_seen - h0), 129'(1));
    check("stray_done_valid", 129'(g), 129'(0));
    check("tmo_sticky",       129'(o_fTimeout), 129'(1));

    // Done in the same cycle the timeout would fire: done wins.
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    check("rst_clears_tmo", 129'(o_fTimeout), 129'(0));
    k = rnd128(); b = rnd128();
    stub_lat = TB_TIMEOUT;
    send_frame(k, b, 1'b1, 1'b0);
    recv_result(core_func(k, b, 1'b1), 0, "race");
    check("race_no_flag", 129'(o_fTimeout), 129'(0));

    check("odata_outside_load", 129'(odata_bad), 129'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/seed_word_loader.md
Name: seed_word_loader

Overview:
- Upstream/downstream adapter for the SEED128 core.
- Collects a 128-bit key, a 128-bit block and a mode bit from a 32-bit valid/ready word stream, then drives the core's 129-bit two-cycle load protocol.
- Waits for the core's done pulse, captures the 128-bit result and returns it as four 32-bit words on a second valid/ready stream.
- One operation is in flight at a time.

Parameters:
- TIMEOUT, 255: maximum cycles spent in WAIT before the timeout flag is raised (8-bit counter; legal range 120..255).

Ports:
- i_Clk  in  1  clock; all logic on rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_Word  in  32  input word: key0..key3 then data0..data3, most significant word first
- i_fValid  in  1  input word valid
- i_fDec  in  1  mode; sampled with the key0 beat only (1 = decrypt)
- o_fReady  out  1  input ready
- o_Data  out  129  to core i_Data; bit 128 is the core's first/mode flag
- i_Text  in  128  from core o_Text
- i_fDone  in  1  from core o_fDone
- o_Word  out  32  result word, most significant first
- o_fValid  out  1  result word valid
- i_fReady  in  1  result word ready
- o_fBusy  out  1  high in every state except COLLECT
- o_fTimeout  out  1  sticky timeout flag

Behaviour:
- Reset (i_Rst=1 at a clock edge) forces:
  - state=COLLECT, beat count=0, timeout count=0
  - key/block/result registers=0, mode=0
  - o_Data=0, o_fValid=0, o_fTimeout=0, o_fBusy=0; o_fReady=1 from the first cycle after reset.
- Reset mid-operation discards all captured data. The core has its own reset and must be reset together with this block.
- A beat transfers when i_fValid & o_fReady. A result beat transfers when o_fValid & i_fReady.
- COLLECT:
  - o_fReady=1.
  - Beats 0..3 fill key[127:0] from the MS word down; beat 0 also latches i_fDec.
  - Beats 4..7 fill block[127:0] the same way.
  - The 3-bit count wraps 7→0. On the beat-7 transfer, go to LOAD_BLK.
- LOAD_BLK (1 cycle): o_Data={1'b1, block}; o_fReady=0. The core is in IDLE and latches the block.
- LOAD_KEY (1 cycle): o_Data={mode, key}. The core is in GETKEY and latches key and mode.
- WAIT:
  - o_Data=0; bit 128 must be 0 here so the core does not restart after its DONE→IDLE.
  - Timeout counter increments each cycle.
  - On i_fDone=1: capture i_Text into the result register, go to OUT. i_Text is only non-zero while i_fDone=1.
  - Expected latency from LOAD_KEY to i_fDone: about 82 cycles for encrypt, 114 for decrypt. No fixed latency is assumed; the done pulse is authoritative.
  - Timeout: if the count reaches TIMEOUT with no i_fDone, set o_fTimeout (cleared only by reset) and go to COLLECT. A later stray i_fDone outside WAIT is ignored.
  - If i_fDone and the timeout fire in the same cycle, i_fDone wins: capture and no flag.
- OUT:
  - o_fValid=1. o_Word presents result[127:96], [95:64], [63:32], [31:0] in order, advancing only on a transfer.
  - o_Word is stable while o_fValid & !i_fReady.
  - After the 4th transfer go to COLLECT. o_fReady=1 on the next cycle; no input is accepted during OUT.
- o_Data is 0 in every state except LOAD_BLK and LOAD_KEY.
- An input stall mid-frame (i_fValid=0) holds the beat count indefinitely; there is no input timeout.
- Every register field has a defined value on every clock.

Test Plan:
- Reset mid-frame: send 5 beats, assert i_Rst for one cycle, then send a full frame → response matches a fresh run. o_fTimeout=0, o_Data=0 throughout reset.
- Encrypt vector (real core): key=0, block=00010203_04050607_08090A0B_0C0D0E0F, i_fDec=0 → o_Word sequence 5EBAC6E0, 054E1668, 19AFF1CC, 6D346CDB. o_Data bit 128 is high for exactly one cycle.
- Decrypt round trip: key=0, block=5EBAC6E0_054E1668_19AFF1CC_6D346CDB, i_fDec=1 → 00010203, 04050607, 08090A0B, 0C0D0E0F.
- Backpressure: toggle i_fValid randomly during input; hold i_fReady=0 for 10 cycles on each output word → identical words, each o_Word stable while stalled, no duplicates and no drops.
- Timeout (stub core, no done): o_fTimeout rises exactly TIMEOUT cycles after WAIT entry and block returns to COLLECT. A stub done pulse 5 cycles later is ignored (o_fValid stays 0).
- Simultaneous done and timeout (stub asserts done in cycle TIMEOUT) → result captured, o_fTimeout=0.
